// File: rtl/ff_exercise_sequencer.sv
// Stimulus sequencer for the lab SR and D flip-flop boards: walks the SR transition table,
// then toggles the D flop, checks each settled response and reports BUSY/DONE/PASS plus error info.
module ff_exercise_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int D_STEPS       = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       Q_IN,
    input  logic       QBAR_IN,
    input  logic       P_IN,
    output logic       R,
    output logic       S,
    output logic       D,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [3:0] ERR_COUNT,
    output logic [3:0] ERR_STEP
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CHECK,
        ST_FIN
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'(8 + D_STEPS - 1);
    localparam logic [3:0] SETTLE    = 4'(SETTLE_CYCLES);

    // SR transition table, bit i belongs to step i
    localparam logic [7:0] SR_R_TAB = 8'b1110_0001;
    localparam logic [7:0] SR_S_TAB = 8'b1101_0100;
    localparam logic [7:0] SR_Q_TAB = 8'b0001_1100;

    state_t     state_q;
    logic [3:0] step_q;
    logic [3:0] cnt_q;
    logic       r_q, s_q, d_q;
    logic       busy_q, done_q, pass_q;
    logic [3:0] err_cnt_q;
    logic [3:0] err_step_q;

    logic       step_err_d;
    logic [3:0] err_cnt_d;

    // Steps 6 and 7 drive R=S=1, an illegal SR input, so they never flag an error
    always_comb begin
        step_err_d = 1'b0;
        if (step_q[3]) begin
            step_err_d = (P_IN != ~step_q[0]);
        end else if (step_q[2:1] != 2'b11) begin
            step_err_d = (Q_IN != SR_Q_TAB[step_q[2:0]]) || (Q_IN == QBAR_IN);
        end
    end

    assign err_cnt_d = (err_cnt_q == 4'hF) ? err_cnt_q : err_cnt_q + 4'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            step_q     <= 4'd0;
            cnt_q      <= 4'd0;
            r_q        <= 1'b1;
            s_q        <= 1'b0;
            d_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= 4'd0;
            err_step_q <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        err_cnt_q  <= 4'd0;
                        err_step_q <= 4'd0;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        step_q     <= 4'd0;
                        state_q    <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (step_q[3]) begin
                        r_q <= 1'b1;
                        s_q <= 1'b0;
                        d_q <= ~step_q[0];
                    end else begin
                        r_q <= SR_R_TAB[step_q[2:0]];
                        s_q <= SR_S_TAB[step_q[2:0]];
                    end
                    cnt_q   <= SETTLE;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (step_err_d) begin
                        err_cnt_q <= err_cnt_d;
                        if (err_cnt_q == 4'd0) begin
                            err_step_q <= step_q;
                        end
                    end
                    if (step_q == LAST_STEP) begin
                        state_q <= ST_FIN;
                    end else begin
                        step_q  <= step_q + 4'd1;
                        state_q <= ST_APPLY;
                    end
                end
                ST_FIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_cnt_q == 4'd0);
                    r_q     <= 1'b1;
                    s_q     <= 1'b0;
                    d_q     <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign R         = r_q;
    assign S         = s_q;
    assign D         = d_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign ERR_COUNT = err_cnt_q;
    assign ERR_STEP  = err_step_q;

endmodule

// File: tb/tb_ff_exercise_sequencer.sv
// Bench for ff_exercise_sequencer: behavioural SR/D flop board with per-step fault overrides,
// expected results derived from the transition table and step timing.
module tb_ff_exercise_sequencer;

    localparam int SET      = 2;
    localparam int DST      = 6;
    localparam int STEPS    = 8 + DST;
    localparam int STEP_LEN = SET + 2;
    localparam int RUN_LEN  = STEPS * STEP_LEN + 1;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic       Q_IN, QBAR_IN, P_IN;
    logic       R, S, D, BUSY, DONE, PASS;
    logic [3:0] ERR_COUNT, ERR_STEP;

    always #5 CLK = ~CLK;

    ff_exercise_sequencer #(.SETTLE_CYCLES(SET), .D_STEPS(DST)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .Q_IN(Q_IN), .QBAR_IN(QBAR_IN), .P_IN(P_IN),
        .R(R), .S(S), .D(D), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
        .ERR_COUNT(ERR_COUNT), .ERR_STEP(ERR_STEP)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Transition table: {R,S} drive and expected Q per SR step
    int r_tab[8]     = '{1, 0, 0, 0, 0, 1, 1, 1};
    int s_tab[8]     = '{0, 0, 1, 0, 1, 0, 1, 1};
    int exp_q_tab[6] = '{0, 0, 1, 1, 1, 0};

    // Override codes per step: 0 = real flop value, 1 = force 0, 2 = force 1
    int   ov_q[STEPS];
    int   ov_qb[STEPS];
    int   ov_p[STEPS];
    int   tb_cyc = -1;
    int   cur_step;
    logic sr_q = 1'b0;
    logic p_ff = 1'b0;

    always @(R or S) begin
        if (R && !S)      sr_q = 1'b0;
        else if (S && !R) sr_q = 1'b1;
    end

    always @(posedge CLK) p_ff <= D;

    function automatic logic force_v(input int code, input logic v);
        case (code)
            1:       return 1'b0;
            2:       return 1'b1;
            default: return v;
        endcase
    endfunction

    always_comb begin
        cur_step = -1;
        Q_IN     = (R && S) ? 1'b0 : sr_q;
        QBAR_IN  = (R && S) ? 1'b0 : ~sr_q;
        P_IN     = p_ff;
        if (tb_cyc >= 0 && tb_cyc < STEPS * STEP_LEN) begin
            cur_step = tb_cyc / STEP_LEN;
            Q_IN     = force_v(ov_q[cur_step], Q_IN);
            QBAR_IN  = force_v(ov_qb[cur_step], QBAR_IN);
            P_IN     = force_v(ov_p[cur_step], P_IN);
        end
    end

    task automatic clear_ov();
        for (int k = 0; k < STEPS; k++) begin
            ov_q[k]  = 0;
            ov_qb[k] = 0;
            ov_p[k]  = 0;
        end
    endtask

    // Reference: what a correct sequencer should conclude from the values the board presents
    task automatic model(output int cnt, output int first);
        int  expv, qv, qbv, pv;
        bit  err;
        cnt   = 0;
        first = 0;
        for (int k = 0; k < STEPS; k++) begin
            err = 0;
            if (k < 6) begin
                expv = exp_q_tab[k];
                qv   = int'(force_v(ov_q[k], expv[0]));
                qbv  = int'(force_v(ov_qb[k], ~expv[0]));
                err  = (qv != expv) || (qv == qbv);
            end else if (k >= 8) begin
                expv = ((k - 8) % 2 == 0) ? 1 : 0;
                pv   = int'(force_v(ov_p[k], expv[0]));
                err  = (pv != expv);
            end
            if (err) begin
                if (cnt == 0) first = k;
                if (cnt < 15) cnt++;
            end
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check_eq({tag, "_R"}, R, 1);
        check_eq({tag, "_S"}, S, 0);
        check_eq({tag, "_D"}, D, 0);
        check_eq({tag, "_BUSY"}, BUSY, 0);
        check_eq({tag, "_DONE"}, DONE, 0);
        check_eq({tag, "_PASS"}, PASS, 0);
        check_eq({tag, "_ERRCNT"}, ERR_COUNT, 0);
        check_eq({tag, "_ERRSTEP"}, ERR_STEP, 0);
    endtask

    task automatic run_seq(input string name, input int glitch_c, input int abort_c);
        int exp_cnt, exp_first, k;
        model(exp_cnt, exp_first);
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        check_eq({name, "_start_busy"}, BUSY, 1);
        check_eq({name, "_start_done"}, DONE, 0);
        for (int c = 0; c < RUN_LEN; c++) begin
            tb_cyc = c;
            @(negedge CLK);
            if (c % STEP_LEN == STEP_LEN - 1 && c / STEP_LEN < STEPS) begin
                k = c / STEP_LEN;
                if (k < 8) begin
                    check_eq($sformatf("%s_s%0d_R", name, k), R, r_tab[k]);
                    check_eq($sformatf("%s_s%0d_S", name, k), S, s_tab[k]);
                    check_eq($sformatf("%s_s%0d_D", name, k), D, 0);
                end else begin
                    check_eq($sformatf("%s_s%0d_R", name, k), R, 1);
                    check_eq($sformatf("%s_s%0d_S", name, k), S, 0);
                    check_eq($sformatf("%s_s%0d_D", name, k), D, ((k - 8) % 2 == 0) ? 1 : 0);
                end
            end
            if (c == abort_c) begin
                RST = 1'b1;
                @(posedge CLK);
                #1;
                RST    = 1'b0;
                tb_cyc = -1;
                check_idle_reset({name, "_abort"});
                return;
            end
            if (c == RUN_LEN - 1) check_eq({name, "_busy_last"}, BUSY, 1);
            if (c == glitch_c) START = 1'b1;
            @(posedge CLK);
            #1;
            START = 1'b0;
        end
        tb_cyc = -1;
        check_eq({name, "_end_busy"}, BUSY, 0);
        check_eq({name, "_end_done"}, DONE, 1);
        check_eq({name, "_end_pass"}, PASS, (exp_cnt == 0) ? 1 : 0);
        check_eq({name, "_end_errcnt"}, ERR_COUNT, exp_cnt);
        check_eq({name, "_end_errstep"}, ERR_STEP, exp_first);
        check_eq({name, "_end_R"}, R, 1);
        check_eq({name, "_end_D"}, D, 0);
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        clear_ov();
        repeat (3) @(posedge CLK);
        #1;
        check_idle_reset("reset");
        RST = 1'b0;

        run_seq("ideal", -1, -1);

        for (int k = 0; k < STEPS; k++) ov_q[k] = 1;
        run_seq("q_stuck0", -1, -1);

        for (int k = 0; k < STEPS; k++) begin
            ov_q[k]  = 2;
            ov_qb[k] = 2;
        end
        run_seq("q_eq_qbar", -1, -1);

        clear_ov();
        for (int k = 0; k < STEPS; k++) ov_p[k] = 2;
        run_seq("p_stuck1", -1, -1);

        // Errors already counted at steps 2 and 3 when reset lands in step 4's WAIT
        clear_ov();
        for (int k = 0; k < STEPS; k++) ov_q[k] = 1;
        run_seq("abort", -1, 4 * STEP_LEN + 1);
        clear_ov();
        run_seq("after_abort", -1, -1);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < STEPS; k++) begin
                ov_q[k]  = ($urandom_range(0, 5) >= 4) ? int'($urandom_range(1, 2)) : 0;
                ov_qb[k] = ($urandom_range(0, 7) >= 6) ? int'($urandom_range(1, 2)) : 0;
                ov_p[k]  = ($urandom_range(0, 5) >= 4) ? int'($urandom_range(1, 2)) : 0;
            end
            run_seq($sformatf("rand%0d", r), (r < 3) ? 10 + 13 * r : -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
